// File: rtl/keypad_scan_debounce.sv
// keypad_scan_debounce
// Scans a 4x4 active-low matrix keypad one column at a time, resolves each full
// four-column frame to a single key (lowest column, then lowest row wins),
// debounces the frame results and emits one event per physical press.
//
// Ports
//   clk          system clock
//   rst          synchronous active-high reset
//   row[3:0]     keypad rows, active-low, asynchronous to clk
//   col[3:0]     column drive, active-low one-hot
//   key_code     last accepted key, col_idx*4 + row_idx
//   key_valid    one-clk pulse per accepted press
//   key_held     high while the accepted key is considered down
//   press_count  accepted-press counter, wraps 7 -> 0
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | no key accepted, waiting for a frame with a key
// PRESS_CHK | candidate key seen, counting matching frames
// HELD      | key accepted, waiting for an empty frame
// REL_CHK   | empty frames seen while held, counting toward release
module keypad_scan_debounce #(
    parameter int SCAN_DIV       = 12500,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held,
    output logic [2:0] press_count
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_CHK = 2'd1,
        HELD      = 2'd2,
        REL_CHK   = 2'd3
    } state_t;

    state_t             state, state_n;
    logic [3:0]         row_s1, row_s2;
    logic [DIV_W-1:0]   div;
    logic [1:0]         col_idx;
    logic               tick;
    logic               frame_done;

    logic               acc_found;
    logic [3:0]         acc_code;
    logic               row_hit;
    logic [1:0]         row_first;
    logic               cur_found;
    logic [3:0]         cur_code;

    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [3:0]         cand, cand_n;
    logic [3:0]         code_n;
    logic               valid_n;
    logic [2:0]         count_n;

    assign tick       = (div == DIV_W'(SCAN_DIV - 1));
    assign frame_done = tick && (col_idx == 2'd3);
    assign col        = ~(4'b0001 << col_idx);
    assign key_held   = (state == HELD) || (state == REL_CHK);

    // Lowest low row in the current column sample.
    always_comb begin
        row_hit   = 1'b0;
        row_first = 2'd0;
        for (int r = 3; r >= 0; r--) begin
            if (!row_s2[r]) begin
                row_hit   = 1'b1;
                row_first = 2'(r);
            end
        end
    end

    // Frame result including the current sample; column 0 starts a new frame,
    // later columns only contribute if nothing was found in earlier ones.
    always_comb begin
        if ((col_idx == 2'd0) || !acc_found) begin
            cur_found = row_hit;
            cur_code  = {col_idx, row_first};
        end else begin
            cur_found = 1'b1;
            cur_code  = acc_code;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cand_n  = cand;
        code_n  = key_code;
        valid_n = 1'b0;
        count_n = press_count;
        if (frame_done) begin
            case (state)
                IDLE: begin
                    if (cur_found) begin
                        cand_n = cur_code;
                        cnt_n  = CNT_W'(1);
                        if (DEBOUNCE_SCANS == 1) begin
                            state_n = HELD;
                            code_n  = cur_code;
                            valid_n = 1'b1;
                            count_n = press_count + 3'd1;
                        end else begin
                            state_n = PRESS_CHK;
                        end
                    end
                end
                PRESS_CHK: begin
                    if (!cur_found) begin
                        state_n = IDLE;
                    end else if (cur_code == cand) begin
                        cnt_n = cnt + CNT_W'(1);
                        if (cnt_n == CNT_W'(DEBOUNCE_SCANS)) begin
                            state_n = HELD;
                            code_n  = cand;
                            valid_n = 1'b1;
                            count_n = press_count + 3'd1;
                        end
                    end else begin
                        cand_n = cur_code;
                        cnt_n  = CNT_W'(1);
                    end
                end
                HELD: begin
                    if (!cur_found) begin
                        cnt_n   = CNT_W'(1);
                        state_n = (DEBOUNCE_SCANS == 1) ? IDLE : REL_CHK;
                    end
                end
                REL_CHK: begin
                    if (cur_found) begin
                        state_n = HELD;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                        if (cnt_n == CNT_W'(DEBOUNCE_SCANS)) begin
                            state_n = IDLE;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_s1      <= 4'hF;
            row_s2      <= 4'hF;
            div         <= '0;
            col_idx     <= 2'd0;
            acc_found   <= 1'b0;
            acc_code    <= 4'd0;
            state       <= IDLE;
            cnt         <= '0;
            cand        <= 4'd0;
            key_code    <= 4'd0;
            key_valid   <= 1'b0;
            press_count <= 3'd0;
        end else begin
            row_s1      <= row;
            row_s2      <= row_s1;
            div         <= tick ? '0 : div + DIV_W'(1);
            if (tick) begin
                col_idx   <= col_idx + 2'd1;
                acc_found <= cur_found;
                acc_code  <= cur_code;
            end
            state       <= state_n;
            cnt         <= cnt_n;
            cand        <= cand_n;
            key_code    <= code_n;
            key_valid   <= valid_n;
            press_count <= count_n;
        end
    end

endmodule

// File: tb/tb_keypad_scan_debounce.sv
module tb_keypad_scan_debounce;

    localparam int D = 2;
    localparam int NONE = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    logic [2:0] press_count;

    logic [15:0] mask = 16'h0000;   // bit k set = key with code k pressed

    int total = 0;
    int bad = 0;
    int pulses = 0;

    // Reference model state (frame-level: run length of identical frame results)
    logic [3:0] m_phase;
    int         m_last;
    int         m_run;
    logic       m_held;
    logic [3:0] m_code;
    logic       m_valid;
    logic [2:0] m_cnt;

    keypad_scan_debounce #(.SCAN_DIV(4), .DEBOUNCE_SCANS(D)) dut (
        .clk(clk), .rst(rst), .row(row), .col(col), .key_code(key_code),
        .key_valid(key_valid), .key_held(key_held), .press_count(press_count)
    );

    always #5 clk = ~clk;

    // Physical keypad: a pressed key shorts its row to its column driver.
    always_comb begin
        row = 4'hF;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (mask[c*4+r] && !col[c]) row[r] = 1'b0;
    end

    function automatic int lowest(input logic [15:0] m);
        for (int k = 0; k < 16; k++) if (m[k]) return k;
        return NONE;
    endfunction

    function automatic int next_run(input int res, input int last, input int run);
        return (res == last) ? run + 1 : 1;
    endfunction

    always @(posedge clk) begin
        if (key_valid) pulses <= pulses + 1;
    end

    always @(posedge clk) begin
        if (rst) begin
            m_phase <= 4'd0;
            m_last  <= -1;
            m_run   <= 0;
            m_held  <= 1'b0;
            m_code  <= 4'd0;
            m_valid <= 1'b0;
            m_cnt   <= 3'd0;
        end else begin
            m_phase <= m_phase + 4'd1;
            m_valid <= 1'b0;
            if (m_phase == 4'd15) begin
                m_last <= lowest(mask);
                m_run  <= next_run(lowest(mask), m_last, m_run);
                if (!m_held && lowest(mask) != NONE &&
                    next_run(lowest(mask), m_last, m_run) == D) begin
                    m_held  <= 1'b1;
                    m_code  <= 4'(lowest(mask));
                    m_valid <= 1'b1;
                    m_cnt   <= m_cnt + 3'd1;
                end else if (m_held && lowest(mask) == NONE &&
                             next_run(lowest(mask), m_last, m_run) == D) begin
                    m_held <= 1'b0;
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", nm, act, req, $time);
        end
    endtask

    // Advance one clock and compare every output against the model.
    task automatic step();
        logic [3:0]  one;
        logic [12:0] exp_v;
        logic [12:0] act_v;
        @(negedge clk);
        one   = 4'b0001;
        exp_v = {~(one << m_phase[3:2]), m_code, m_valid, m_held, m_cnt};
        act_v = {col, key_code, key_valid, key_held, press_count};
        chk("cycle{col,code,valid,held,count}", int'(act_v), int'(exp_v));
    endtask

    task automatic frames(input logic [15:0] m, input int n);
        for (int f = 0; f < n; f++) begin
            mask = m;
            repeat (16) step();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] seq [4];
        int base;
        seq[0] = 4'b1110; seq[1] = 4'b1101; seq[2] = 4'b1011; seq[3] = 4'b0111;

        // Reset values and column sequence
        do_reset();
        chk("rst_code", key_code, 0);
        chk("rst_valid", key_valid, 0);
        chk("rst_held", key_held, 0);
        chk("rst_count", press_count, 0);
        mask = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            chk("col_seq", col, seq[i]);
            repeat (4) step();
        end

        // Key col2/row1 held six frames, then released
        base = pulses;
        frames(16'h0200, 6);
        chk("k9_held", key_held, 1);
        chk("k9_code", key_code, 9);
        chk("k9_count", press_count, 1);
        chk("k9_model_count", m_cnt, 1);
        frames(16'h0000, 1);
        chk("k9_held_after1", key_held, 1);
        frames(16'h0000, 1);
        chk("k9_released", key_held, 0);
        chk("k9_code_kept", key_code, 9);
        chk("k9_pulses", pulses - base, 1);

        // Bounce never reaches two matching frames
        do_reset();
        base = pulses;
        for (int i = 0; i < 4; i++) begin
            frames(16'h0040, 1);
            frames(16'h0000, 1);
        end
        chk("bounce_count", press_count, 0);
        chk("bounce_pulses", pulses - base, 0);
        chk("bounce_held", key_held, 0);

        // Two keys at once, then switch while held
        base = pulses;
        frames(16'h0018, 3);
        chk("two_code", key_code, 3);
        chk("two_model_code", m_code, 3);
        frames(16'h8000, 3);
        chk("switch_code", key_code, 3);
        chk("switch_held", key_held, 1);
        chk("switch_pulses", pulses - base, 1);
        frames(16'h0000, 3);

        // Eight clean press/release cycles, count wraps
        do_reset();
        base = pulses;
        for (int i = 0; i < 8; i++) begin
            frames(16'(1) << $urandom_range(0, 15), 3);
            chk("wrap_count", press_count, (i + 1) % 8);
            frames(16'h0000, 3);
        end
        chk("wrap_pulses", pulses - base, 8);

        // Reset while held, key still down
        frames(16'h0020, 3);
        chk("pre_rst_held", key_held, 1);
        do_reset();
        chk("rst_held_held", key_held, 0);
        chk("rst_held_code", key_code, 0);
        chk("rst_held_count", press_count, 0);
        base = pulses;
        frames(16'h0020, 3);
        chk("redetect_count", press_count, 1);
        chk("redetect_code", key_code, 5);
        chk("redetect_pulses", pulses - base, 1);
        frames(16'h0000, 3);

        // Random frames
        for (int f = 0; f < 80; f++) begin
            case ($urandom_range(0, 3))
                0: mask = 16'h0000;
                1: mask = 16'(1) << $urandom_range(0, 15);
                2: mask = 16'($urandom);
                default: ;
            endcase
            frames(mask, $urandom_range(1, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
